wb_uart_rx: RTL and testbench

UART receiver for the Z80 breadboard computer SoC, the receive-side counterpart of the byte-wide Wishbone UART transmitter. It samples the asynchronous serial line with a 2-flop synchronizer and frames 8N1 characters at mid-bit. Received bytes are buffered in an internal FIFO. The CPU-side bus bridge pops bytes over a reduced Wishbone read port.

---
 rtl/uart_pkg.sv | 17 +
 rtl/rx_byte_fifo.sv | 55 +++++
 rtl/wb_uart_rx.sv | 167 ++++++++++++++++
 tb/tb_wb_uart_rx.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the Z80 SoC UART receive path.
// Holds the receiver state encodings and the 8N1 frame constants.
package uart_pkg;

    typedef enum logic [2:0] {
        RX_IDLE      = 3'd0,
        RX_START     = 3'd1,
        RX_DATA      = 3'd2,
        RX_STOP      = 3'd3,
        RX_WAIT_IDLE = 3'd4
    } rx_state_t;

    localparam int   UART_DATA_BITS  = 8;
    localparam int   UART_STOP_BITS  = 1;
    localparam logic UART_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/rx_byte_fifo.sv
// Register-array synchronous byte FIFO with registered read data.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module rx_byte_fifo #(
    parameter int FIFO_AW = 5
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    output logic [7:0] pop_data,
    output logic       full,
    output logic       empty
);

    localparam int DEPTH = 2 ** FIFO_AW;

    logic [7:0]       r_mem [DEPTH];
    logic [FIFO_AW:0] r_wr_ptr;
    logic [FIFO_AW:0] r_rd_ptr;
    logic [7:0]       r_pop_data;
    logic             w_do_push;
    logic             w_do_pop;

    assign empty     = (r_wr_ptr == r_rd_ptr);
    assign full      = (r_wr_ptr[FIFO_AW] != r_rd_ptr[FIFO_AW]) &&
                       (r_wr_ptr[FIFO_AW-1:0] == r_rd_ptr[FIFO_AW-1:0]);
    assign w_do_pop  = pop && !empty;
    // A simultaneous pop frees the slot, so a push into a full FIFO is legal then.
    assign w_do_push = push && (!full || w_do_pop);
    assign pop_data  = r_pop_data;

    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[FIFO_AW-1:0]] <= push_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_pop_data <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr   <= r_rd_ptr + 1'b1;
                r_pop_data <= r_mem[r_rd_ptr[FIFO_AW-1:0]];
            end
        end
    end

endmodule

// File: rtl/wb_uart_rx.sv
// 8N1 UART receiver with mid-bit sampling, a byte FIFO and a Wishbone pop port.
// The serial line is synchronised through two flops before any decision is made.
module wb_uart_rx
    import uart_pkg::*;
#(
    parameter int BAUD_DIV_RATE  = 2604,
    parameter int BAUD_DIV_WIDTH = 12,
    parameter int FIFO_AW        = 5
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_wb_cyc,
    input  logic       i_wb_stb,
    output logic [7:0] o_wb_data,
    output logic       o_wb_ack,
    output logic       o_wb_stall,
    output logic       o_rx_empty,
    output logic       o_rx_full,
    output logic       o_frame_err,
    output logic       o_overrun,
    input  logic       uart_rx
);

    localparam logic [BAUD_DIV_WIDTH-1:0] TICK_VAL = BAUD_DIV_WIDTH'(BAUD_DIV_RATE - 1);
    localparam logic [BAUD_DIV_WIDTH-1:0] HALF_VAL = BAUD_DIV_WIDTH'((BAUD_DIV_RATE >> 1) - 1);
    localparam logic [2:0]                LAST_BIT = 3'(UART_DATA_BITS - 1);

    logic                      r_sync1;
    logic                      r_sync2;
    logic                      w_rx_s;
    rx_state_t                 r_state;
    rx_state_t                 w_state_next;
    logic [BAUD_DIV_WIDTH-1:0] r_baud;
    logic [BAUD_DIV_WIDTH-1:0] w_baud_next;
    logic [2:0]                r_bit_cnt;
    logic [2:0]                w_bit_cnt_next;
    logic [7:0]                r_shift;
    logic [7:0]                w_shift_next;
    logic                      w_tick;
    logic                      w_half;
    logic                      w_push_req;
    logic                      w_frame_err;
    logic                      w_pop;
    logic                      w_push;
    logic                      w_full;
    logic                      w_empty;
    logic [7:0]                w_pop_data;
    logic                      r_ack;
    logic                      r_frame_err;
    logic                      r_overrun;

    assign w_rx_s = r_sync2;
    assign w_tick = (r_baud == TICK_VAL);
    assign w_half = (r_baud == HALF_VAL);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sync1   <= UART_IDLE_LEVEL;
            r_sync2   <= UART_IDLE_LEVEL;
            r_state   <= RX_IDLE;
            r_baud    <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
        end else begin
            r_sync1   <= uart_rx;
            r_sync2   <= r_sync1;
            r_state   <= w_state_next;
            r_baud    <= w_baud_next;
            r_bit_cnt <= w_bit_cnt_next;
            r_shift   <= w_shift_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_baud_next    = w_tick ? '0 : r_baud + 1'b1;
        w_bit_cnt_next = r_bit_cnt;
        w_shift_next   = r_shift;
        w_push_req     = 1'b0;
        w_frame_err    = 1'b0;
        case (r_state)
            RX_IDLE: begin
                if (!w_rx_s) begin
                    w_state_next = RX_START;
                    w_baud_next  = '0;
                end
            end
            RX_START: begin
                // A start bit that has gone high again by mid-bit is treated as noise.
                if (w_half) begin
                    if (w_rx_s) begin
                        w_state_next = RX_IDLE;
                    end else begin
                        w_state_next   = RX_DATA;
                        w_baud_next    = '0;
                        w_bit_cnt_next = '0;
                    end
                end
            end
            RX_DATA: begin
                if (w_tick) begin
                    w_shift_next   = {w_rx_s, r_shift[7:1]};
                    w_bit_cnt_next = r_bit_cnt + 1'b1;
                    if (r_bit_cnt == LAST_BIT) begin
                        w_state_next = RX_STOP;
                    end
                end
            end
            RX_STOP: begin
                if (w_tick) begin
                    if (w_rx_s) begin
                        w_push_req   = 1'b1;
                        w_state_next = RX_IDLE;
                    end else begin
                        w_frame_err  = 1'b1;
                        w_state_next = RX_WAIT_IDLE;
                    end
                end
            end
            RX_WAIT_IDLE: begin
                if (w_rx_s) begin
                    w_state_next = RX_IDLE;
                end
            end
            default: begin
                w_state_next = RX_IDLE;
            end
        endcase
    end

    assign w_pop  = i_wb_cyc && i_wb_stb && !w_empty;
    assign w_push = w_push_req && (!w_full || w_pop);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_ack       <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_ack       <= w_pop;
            r_frame_err <= w_frame_err;
            r_overrun   <= w_push_req && w_full && !w_pop;
        end
    end

    rx_byte_fifo #(
        .FIFO_AW (FIFO_AW)
    ) u_fifo (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .push      (w_push),
        .push_data (r_shift),
        .pop       (w_pop),
        .pop_data  (w_pop_data),
        .full      (w_full),
        .empty     (w_empty)
    );

    assign o_wb_data   = w_pop_data;
    assign o_wb_ack    = r_ack;
    assign o_wb_stall  = w_empty;
    assign o_rx_empty  = w_empty;
    assign o_rx_full   = w_full;
    assign o_frame_err = r_frame_err;
    assign o_overrun   = r_overrun;

endmodule

// File: tb/tb_wb_uart_rx.sv
// Directed bench for wb_uart_rx at 16 clocks per bit.
// Each scenario task drives the line/bus and checks its own expectations inline.
module tb_wb_uart_rx;

    localparam int BIT = 16;

    logic       clk      = 1'b0;
    logic       i_reset  = 1'b1;
    logic       i_wb_cyc = 1'b0;
    logic       i_wb_stb = 1'b0;
    logic       uart_rx  = 1'b1;
    logic [7:0] o_wb_data;
    logic       o_wb_ack;
    logic       o_wb_stall;
    logic       o_rx_empty;
    logic       o_rx_full;
    logic       o_frame_err;
    logic       o_overrun;

    int total = 0;
    int bad   = 0;
    int fe_total = 0;
    int ov_total = 0;

    always #5 clk = ~clk;

    wb_uart_rx #(
        .BAUD_DIV_RATE  (BIT),
        .BAUD_DIV_WIDTH (12),
        .FIFO_AW        (5)
    ) dut (
        .i_clk       (clk),
        .i_reset     (i_reset),
        .i_wb_cyc    (i_wb_cyc),
        .i_wb_stb    (i_wb_stb),
        .o_wb_data   (o_wb_data),
        .o_wb_ack    (o_wb_ack),
        .o_wb_stall  (o_wb_stall),
        .o_rx_empty  (o_rx_empty),
        .o_rx_full   (o_rx_full),
        .o_frame_err (o_frame_err),
        .o_overrun   (o_overrun),
        .uart_rx     (uart_rx)
    );

    always @(posedge clk) begin
        if (o_frame_err) fe_total <= fe_total + 1;
        if (o_overrun)   ov_total <= ov_total + 1;
    end

    task automatic line_bit(input logic v);
        uart_rx = v;
        repeat (BIT) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop_lvl);
        line_bit(1'b0);
        for (int i = 0; i < 8; i++) line_bit(d[i]);
        line_bit(stop_lvl);
    endtask

    task automatic wb_pop(output logic ack, output logic [7:0] d);
        i_wb_cyc = 1'b1;
        i_wb_stb = 1'b1;
        @(negedge clk);
        i_wb_cyc = 1'b0;
        i_wb_stb = 1'b0;
        ack = o_wb_ack;
        d   = o_wb_data;
    endtask

    task automatic test_reset();
        i_reset = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (o_wb_ack !== 1'b0)    begin bad++; $display("FAIL reset_ack got=%b want=0", o_wb_ack); end
        total++; if (o_wb_data !== 8'h00)  begin bad++; $display("FAIL reset_data got=%h want=00", o_wb_data); end
        total++; if (o_wb_stall !== 1'b1)  begin bad++; $display("FAIL reset_stall got=%b want=1", o_wb_stall); end
        total++; if (o_rx_empty !== 1'b1)  begin bad++; $display("FAIL reset_empty got=%b want=1", o_rx_empty); end
        total++; if (o_rx_full !== 1'b0)   begin bad++; $display("FAIL reset_full got=%b want=0", o_rx_full); end
        total++; if (o_frame_err !== 1'b0) begin bad++; $display("FAIL reset_fe got=%b want=0", o_frame_err); end
        total++; if (o_overrun !== 1'b0)   begin bad++; $display("FAIL reset_ov got=%b want=0", o_overrun); end
        i_reset = 1'b0;
        repeat (4) @(negedge clk);
        $display("test_reset done");
    endtask

    task automatic test_basic();
        logic ack;
        logic [7:0] d;
        line_bit(1'b0);
        for (int i = 0; i < 8; i++) line_bit(logic'(8'hA5 >> i));
        total++; if (o_rx_empty !== 1'b1) begin bad++; $display("FAIL basic_early_empty got=%b want=1", o_rx_empty); end
        line_bit(1'b1);
        total++; if (o_rx_empty !== 1'b0) begin bad++; $display("FAIL basic_empty_fall got=%b want=0", o_rx_empty); end
        wb_pop(ack, d);
        total++; if (ack !== 1'b1 || d !== 8'hA5) begin bad++; $display("FAIL basic_pop ack=%b data=%h want ack=1 data=a5", ack, d); end
        total++; if (o_rx_empty !== 1'b1) begin bad++; $display("FAIL basic_empty_after got=%b want=1", o_rx_empty); end
        wb_pop(ack, d);
        total++; if (ack !== 1'b0) begin bad++; $display("FAIL basic_stalled_pop ack=%b want=0", ack); end
        $display("test_basic: sent a5 popped %h", 8'hA5);
    endtask

    task automatic test_glitch();
        int fe0 = fe_total;
        uart_rx = 1'b0;
        repeat (4) @(negedge clk);
        uart_rx = 1'b1;
        repeat (3 * BIT) @(negedge clk);
        total++; if (o_rx_empty !== 1'b1) begin bad++; $display("FAIL glitch_empty got=%b want=1", o_rx_empty); end
        total++; if (fe_total != fe0) begin bad++; $display("FAIL glitch_fe got=%0d want=0", fe_total - fe0); end
        $display("test_glitch done");
    endtask

    task automatic test_frame_error();
        int fe0 = fe_total;
        logic ack;
        logic [7:0] d;
        send_byte(8'h3C, 1'b0);
        uart_rx = 1'b0;
        repeat (3 * BIT) @(negedge clk);
        uart_rx = 1'b1;
        repeat (2 * BIT) @(negedge clk);
        total++; if (fe_total - fe0 != 1) begin bad++; $display("FAIL ferr_count got=%0d want=1", fe_total - fe0); end
        total++; if (o_rx_empty !== 1'b1) begin bad++; $display("FAIL ferr_empty got=%b want=1", o_rx_empty); end
        send_byte(8'h42, 1'b1);
        repeat (2) @(negedge clk);
        wb_pop(ack, d);
        total++; if (ack !== 1'b1 || d !== 8'h42) begin bad++; $display("FAIL ferr_next_byte ack=%b data=%h want ack=1 data=42", ack, d); end
        total++; if (fe_total - fe0 != 1) begin bad++; $display("FAIL ferr_count_after got=%0d want=1", fe_total - fe0); end
        $display("test_frame_error done");
    endtask

    task automatic test_overrun();
        int ov0 = ov_total;
        logic ack;
        logic [7:0] d;
        for (int i = 0; i < 33; i++) begin
            send_byte(8'(i), 1'b1);
            repeat (2) @(negedge clk);
            if (i == 30) begin
                total++; if (o_rx_full !== 1'b0) begin bad++; $display("FAIL ovr_full_31 got=%b want=0", o_rx_full); end
            end
            if (i == 31) begin
                total++; if (o_rx_full !== 1'b1) begin bad++; $display("FAIL ovr_full_32 got=%b want=1", o_rx_full); end
                total++; if (ov_total != ov0) begin bad++; $display("FAIL ovr_early got=%0d want=0", ov_total - ov0); end
            end
        end
        total++; if (ov_total - ov0 != 1) begin bad++; $display("FAIL ovr_count got=%0d want=1", ov_total - ov0); end
        for (int i = 0; i < 32; i++) begin
            wb_pop(ack, d);
            total++; if (ack !== 1'b1 || d !== 8'(i)) begin bad++; $display("FAIL ovr_pop%0d ack=%b data=%h want ack=1 data=%h", i, ack, d, 8'(i)); end
        end
        wb_pop(ack, d);
        total++; if (ack !== 1'b0) begin bad++; $display("FAIL ovr_final_stall ack=%b want=0", ack); end
        $display("test_overrun done");
    endtask

    task automatic test_full_push_pop();
        int ov0;
        logic ack;
        logic [7:0] d;
        for (int i = 0; i < 32; i++) begin
            send_byte(8'h60 + 8'(i), 1'b1);
            repeat (2) @(negedge clk);
        end
        total++; if (o_rx_full !== 1'b1) begin bad++; $display("FAIL fpp_full got=%b want=1", o_rx_full); end
        ov0 = ov_total;
        // Push of 0x99 lands on the 155th edge after the start bit is driven.
        fork
            send_byte(8'h99, 1'b1);
            begin
                repeat (154) @(negedge clk);
                wb_pop(ack, d);
            end
        join
        repeat (2) @(negedge clk);
        total++; if (ack !== 1'b1 || d !== 8'h60) begin bad++; $display("FAIL fpp_same_cycle ack=%b data=%h want ack=1 data=60", ack, d); end
        total++; if (ov_total != ov0) begin bad++; $display("FAIL fpp_overrun got=%0d want=0", ov_total - ov0); end
        total++; if (o_rx_full !== 1'b1) begin bad++; $display("FAIL fpp_still_full got=%b want=1", o_rx_full); end
        for (int i = 1; i <= 32; i++) begin
            logic [7:0] exp_d;
            exp_d = (i == 32) ? 8'h99 : 8'h60 + 8'(i);
            wb_pop(ack, d);
            total++; if (ack !== 1'b1 || d !== exp_d) begin bad++; $display("FAIL fpp_pop%0d ack=%b data=%h want ack=1 data=%h", i, ack, d, exp_d); end
        end
        wb_pop(ack, d);
        total++; if (ack !== 1'b0) begin bad++; $display("FAIL fpp_final_stall ack=%b want=0", ack); end
        $display("test_full_push_pop done");
    endtask

    task automatic test_mid_reset();
        logic ack;
        logic [7:0] d;
        for (int i = 0; i < 5; i++) begin
            send_byte(8'h11 + 8'(i), 1'b1);
            repeat (2) @(negedge clk);
        end
        total++; if (o_rx_empty !== 1'b0) begin bad++; $display("FAIL mrst_buffered got=%b want=0", o_rx_empty); end
        // 0xF0 keeps the line high after bit 3, so the cut-off frame leaves no residue.
        fork
            send_byte(8'hF0, 1'b1);
            begin
                repeat (100) @(negedge clk);
                i_reset = 1'b1;
                @(negedge clk);
                i_reset = 1'b0;
                total++; if (o_wb_ack !== 1'b0)    begin bad++; $display("FAIL mrst_ack got=%b want=0", o_wb_ack); end
                total++; if (o_wb_data !== 8'h00)  begin bad++; $display("FAIL mrst_data got=%h want=00", o_wb_data); end
                total++; if (o_wb_stall !== 1'b1)  begin bad++; $display("FAIL mrst_stall got=%b want=1", o_wb_stall); end
                total++; if (o_rx_empty !== 1'b1)  begin bad++; $display("FAIL mrst_empty got=%b want=1", o_rx_empty); end
                total++; if (o_rx_full !== 1'b0)   begin bad++; $display("FAIL mrst_full got=%b want=0", o_rx_full); end
                total++; if (o_frame_err !== 1'b0) begin bad++; $display("FAIL mrst_fe got=%b want=0", o_frame_err); end
                total++; if (o_overrun !== 1'b0)   begin bad++; $display("FAIL mrst_ov got=%b want=0", o_overrun); end
            end
        join
        repeat (BIT) @(negedge clk);
        total++; if (o_rx_empty !== 1'b1) begin bad++; $display("FAIL mrst_no_residue got=%b want=1", o_rx_empty); end
        send_byte(8'h81, 1'b1);
        repeat (2) @(negedge clk);
        wb_pop(ack, d);
        total++; if (ack !== 1'b1 || d !== 8'h81) begin bad++; $display("FAIL mrst_next_byte ack=%b data=%h want ack=1 data=81", ack, d); end
        total++; if (o_rx_empty !== 1'b1) begin bad++; $display("FAIL mrst_empty_end got=%b want=1", o_rx_empty); end
        $display("test_mid_reset done");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_frame_error();
        test_overrun();
        test_full_push_pop();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
